// File: rtl/m216a_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m216a_pkg
//  Description : Shared constants and state encoding for the multi-modulus
//                divider that follows the MASH 1-1-1 modulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package m216a_pkg;

    localparam int RATIO_W   = 4;   // matches the modulator output word
    localparam int MIN_RATIO = 2;   // smallest period the divider produces

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage : m216a_pkg
`default_nettype wire

// File: rtl/m216a_mmd_divider.sv
`default_nettype none
// ============================================================================
//  Module      : m216a_mmd_divider
//  Description : Multi-modulus divider. Each period lasts exactly the
//                (clamped) ratio word sampled at its start; div_pulse marks
//                the first cycle and strobes the modulator for its next word.
//  Revision    : 1.0 - initial release
// ============================================================================
module m216a_mmd_divider #(
    parameter int RW        = m216a_pkg::RATIO_W,
    parameter int MIN_RATIO = m216a_pkg::MIN_RATIO,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [RW-1:0] ratio,
    output logic          div_pulse,
    output logic          div_clk,
    output logic          ratio_clmp,
    output logic [CW-1:0] pulse_cnt
);

    import m216a_pkg::*;

    localparam logic [RW-1:0] C_MIN_R = RW'(MIN_RATIO);

    state_t        state_q,     state_d;
    logic [RW-1:0] cnt_q,       cnt_d;
    logic [RW-1:0] cur_r_q,     cur_r_d;
    logic          div_pulse_q, div_pulse_d;
    logic          div_clk_q,   div_clk_d;
    logic          clmp_q,      clmp_d;
    logic [CW-1:0] pcnt_q,      pcnt_d;

    logic          w_clamp;
    logic [RW-1:0] w_eff;
    logic          w_load;

    // Effective ratio and the period-start condition.
    always_comb begin
        w_clamp = (ratio < C_MIN_R);
        w_eff   = w_clamp ? C_MIN_R : ratio;
        w_load  = en && ((state_q == S_IDLE) || (cnt_q == '0));
    end

    // Next-state logic: en low wins over a reload; otherwise count down and
    // reload at the end of each period.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_r_d     = cur_r_q;
        div_pulse_d = 1'b0;
        clmp_d      = clmp_q;
        pcnt_d      = pcnt_q;
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (w_load) begin
            state_d     = S_RUN;
            cur_r_d     = w_eff;
            cnt_d       = w_eff - RW'(1);
            div_pulse_d = 1'b1;
            pcnt_d      = pcnt_q + CW'(1);
            clmp_d      = clmp_q | w_clamp;
        end else begin
            cnt_d = cnt_q - RW'(1);
        end
        // High while the down-counter sits in the upper half of the period,
        // giving ceil(R/2) high cycles starting with the pulse cycle.
        div_clk_d = (state_d == S_RUN) && (cnt_d >= (cur_r_d >> 1));
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_r_q     <= C_MIN_R;
            div_pulse_q <= 1'b0;
            div_clk_q   <= 1'b0;
            clmp_q      <= 1'b0;
            pcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_r_q     <= cur_r_d;
            div_pulse_q <= div_pulse_d;
            div_clk_q   <= div_clk_d;
            clmp_q      <= clmp_d;
            pcnt_q      <= pcnt_d;
        end
    end

    assign div_pulse  = div_pulse_q;
    assign div_clk    = div_clk_q;
    assign ratio_clmp = clmp_q;
    assign pulse_cnt  = pcnt_q;

endmodule : m216a_mmd_divider
`default_nettype wire

// File: tb/tb_m216a_mmd_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m216a_mmd_divider
//  Description : Self-checking bench for the multi-modulus divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m216a_mmd_divider;

    localparam int TB_CW = 10;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [3:0]       ratio;
    logic             div_pulse;
    logic             div_clk;
    logic             ratio_clmp;
    logic [TB_CW-1:0] pulse_cnt;

    int checks   = 0;
    int failures = 0;

    m216a_mmd_divider #(.RW(4), .MIN_RATIO(2), .CW(TB_CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ratio      (ratio),
        .div_pulse  (div_pulse),
        .div_clk    (div_clk),
        .ratio_clmp (ratio_clmp),
        .pulse_cnt  (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a period of length R, tracked by an up-counting phase
    // index k = 0..R-1 within the period.
    bit m_run;
    int m_k;
    int m_R;
    int m_cnt;
    bit m_clmp;

    task automatic model_reset();
        m_run = 0; m_k = 0; m_R = 2; m_cnt = 0; m_clmp = 0;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] r);
        if (!e) begin
            m_run = 0;
            m_k   = 0;
        end else if (!m_run || m_k == m_R - 1) begin
            m_R    = (r < 2) ? 2 : int'(r);
            m_clmp = m_clmp | (r < 2);
            m_k    = 0;
            m_run  = 1;
            m_cnt  = (m_cnt + 1) % (1 << TB_CW);
        end else begin
            m_k++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model_pulse", 32'(div_pulse),  32'(m_run && m_k == 0));
        check("model_dclk",  32'(div_clk),    32'(m_run && (m_k < (m_R + 1) / 2)));
        check("model_clmp",  32'(ratio_clmp), 32'(m_clmp));
        check("model_pcnt",  32'(pulse_cnt),  32'(m_cnt));
    endtask

    // Apply inputs for one rising edge, then compare #1 after it.
    task automatic cycle(input logic e, input logic [3:0] r);
        en    = e;
        ratio = r;
        @(posedge clk);
        model_edge(e, r);
        #1;
        check_model();
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pulse", 32'(div_pulse),  32'd0);
        check("rst_dclk",  32'(div_clk),    32'd0);
        check("rst_clmp",  32'(ratio_clmp), 32'd0);
        check("rst_pcnt",  32'(pulse_cnt),  32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] ratio;
        logic       pulse;
        logic       dclk;
        logic       clmp;
        int         pcnt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 4'd4,  1'b1, 1'b1, 1'b0, 1};
        vecs[1]  = '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{1'b1, 4'd2,  1'b1, 1'b1, 1'b0, 2};
        vecs[5]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 3};
        vecs[7]  = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 3};
        vecs[8]  = '{1'b1, 4'd3,  1'b1, 1'b1, 1'b1, 4};
        vecs[9]  = '{1'b0, 4'd3,  1'b0, 1'b0, 1'b1, 4};
        vecs[10] = '{1'b1, 4'd1,  1'b1, 1'b1, 1'b1, 5};
        vecs[11] = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 5};

        rst_n = 1'b0;
        en    = 1'b0;
        ratio = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pulse", 32'(div_pulse),  32'd0);
        check("reset_dclk",  32'(div_clk),    32'd0);
        check("reset_clmp",  32'(ratio_clmp), 32'd0);
        check("reset_pcnt",  32'(pulse_cnt),  32'd0);
        rst_n = 1'b1;

        // Idle with en low stays quiet.
        cycle(1'b0, 4'd4);

        // Table-driven sequence including clamp and en drop.
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].en, vecs[i].ratio);
            check($sformatf("vec%0d_pulse", i), 32'(div_pulse),  32'(vecs[i].pulse));
            check($sformatf("vec%0d_dclk", i),  32'(div_clk),    32'(vecs[i].dclk));
            check($sformatf("vec%0d_clmp", i),  32'(ratio_clmp), 32'(vecs[i].clmp));
            check($sformatf("vec%0d_pcnt", i),  32'(pulse_cnt),  32'(vecs[i].pcnt));
        end

        // Clamp flag clears only on reset.
        do_reset();

        // Constant ratio 4 for 1000 cycles.
        for (int i = 0; i < 1000; i++) cycle(1'b1, 4'd4);
        check("r4_pcnt_1000", 32'(pulse_cnt), 32'd250);

        // Alternate 15 / 2 on successive loads; verify spacing.
        do_reset();
        begin
            bit use15;
            int pos[$];
            use15 = 1;
            for (int i = 0; i < 40; i++) begin
                cycle(1'b1, use15 ? 4'd15 : 4'd2);
                if (m_k == 0) begin
                    use15 = !use15;
                    pos.push_back(i);
                end
            end
            check("alt_npulses", 32'(pos.size()), 32'd5);
            for (int j = 0; j < 4 && j + 1 < pos.size(); j++)
                check($sformatf("alt_gap%0d", j), 32'(pos[j+1] - pos[j]),
                      (j % 2 == 0) ? 32'd15 : 32'd2);
        end

        // en low mid-period at cnt=3 of R=9, then re-raise.
        do_reset();
        cycle(1'b1, 4'd9);
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'd9);
        cycle(1'b0, 4'd9);
        check("enlow_pulse", 32'(div_pulse), 32'd0);
        check("enlow_dclk",  32'(div_clk),   32'd0);
        check("enlow_pcnt",  32'(pulse_cnt), 32'd1);
        cycle(1'b0, 4'd9);
        cycle(1'b1, 4'd9);
        check("reraise_pulse", 32'(div_pulse), 32'd1);
        check("reraise_pcnt",  32'(pulse_cnt), 32'd2);

        // Reset mid-period.
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd9);
        do_reset();

        // Counter wrap: 2^TB_CW loads at period 2.
        for (int i = 0; i < 2 * (1 << TB_CW); i++) begin
            cycle(1'b1, 4'd0);
            if (i == 2 * (1 << TB_CW) - 3)
                check("wrap_pre", 32'(pulse_cnt), 32'((1 << TB_CW) - 1));
        end
        check("wrap_zero", 32'(pulse_cnt), 32'd0);

        // Randomized stimulus against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(599, 0) == 0) do_reset();
            cycle(($urandom_range(9, 0) != 0), 4'($urandom_range(15, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_m216a_mmd_divider
`default_nettype wire
